// File: rtl/debug_scan_pkg.sv
// Shared definitions for the debug scan master.
// Contents: FSM state encodings, TAP reset length, and the fixed pre/postamble
// lengths (in TCK cycles) that surround every IR/DR shift.
package debug_scan_pkg;

    // One TCK cycle per state, except SHIFT (n cycles) and TLR_INIT (6 cycles).
    // Each scan state is named after the TAP state reached at the end of its TCK cycle.
    localparam logic [3:0] ST_TLR_INIT = 4'd0;
    localparam logic [3:0] ST_IDLE     = 4'd1;
    localparam logic [3:0] ST_SEL_DR   = 4'd2;
    localparam logic [3:0] ST_SEL_IR   = 4'd3;
    localparam logic [3:0] ST_CAPTURE  = 4'd4;
    localparam logic [3:0] ST_SHIFT    = 4'd5;
    localparam logic [3:0] ST_EXIT1    = 4'd6;
    localparam logic [3:0] ST_UPDATE   = 4'd7;
    localparam logic [3:0] ST_RTI      = 4'd8;
    localparam logic [3:0] ST_RESP     = 4'd9;

    typedef logic [3:0] scan_state_t;

    // TMS=1 cycles needed to force Test-Logic-Reset from any TAP state.
    localparam int TLR_CYCLES = 5;

    // TCK cycles around the n shift cycles of a scan.
    localparam int DR_PRE_CYCLES = 3;   // Select-DR, Capture, Shift entry
    localparam int IR_PRE_CYCLES = 4;   // extra Select-IR
    localparam int POST_CYCLES   = 2;   // Update, Run-Test/Idle

endpackage

// File: rtl/debug_scan_tck_gen.sv
// TCK divider for the debug scan master.
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   run                 divider enable; when low tck is held 0 and the phase restarts
//   tck                 generated JTAG clock (low phase first)
//   rise_stb/fall_stb   one-clk strobes, high on the clk edge that drives tck 0->1 / 1->0
module debug_scan_tck_gen
    import debug_scan_pkg::*;
#(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tck,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int CNT_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TCK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;
    logic             phase_hi;
    logic             at_last;

    assign at_last  = run && (div_cnt == LAST);
    assign rise_stb = at_last && !phase_hi;
    assign fall_stb = at_last && phase_hi;
    assign tck      = phase_hi;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            phase_hi <= 1'b0;
        end else if (!run) begin
            div_cnt  <= '0;
            phase_hi <= 1'b0;
        end else if (div_cnt == LAST) begin
            div_cnt  <= '0;
            phase_hi <= !phase_hi;
        end else begin
            div_cnt  <= div_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/debug_scan_master.sv
// JTAG scan initiator: turns IR/DR scan commands into TCK/TMS/TDI sequences for an
// IEEE 1149.1 TAP and returns the captured TDO bits.
// Ports:
//   clk, reset_n                 system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_is_ir, cmd_len, cmd_data scan type, bit count, TDI data (LSB first)
//   rsp_valid, rsp_data, rsp_err one-clk completion pulse, captured TDO, illegal length
//   busy                         high whenever not IDLE
//   tck, tms, tdi, tdo           JTAG pins (tck is a data signal)
// Optional build macro: DEBUG_SCAN_RTI_WAIT_EN -- hold Run-Test/Idle for RTI_CYCLES
// TCK cycles after each scan instead of one.
module debug_scan_master
    import debug_scan_pkg::*;
#(
    parameter int DR_WIDTH   = 38,
    parameter int LEN_W      = 6,
    parameter int TCK_DIV    = 2,
    parameter int RTI_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_is_ir,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                rsp_err,
    output logic                busy,
    output logic                tck,
    output logic                tms,
    output logic                tdi,
    input  logic                tdo
);

    if (TCK_DIV < 1 || RTI_CYCLES < 1 || (2 ** LEN_W) <= DR_WIDTH) begin : g_bad_params
        $error("debug_scan_master: illegal parameter combination");
    end

    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(DR_WIDTH);
    // TLR_INIT runs TLR_CYCLES cycles with tms=1 plus one with tms=0; the counter
    // parks at this value for the single clk before IDLE.
    localparam logic [2:0]       TLR_DONE = 3'(TLR_CYCLES + 1);

    scan_state_t         state;
    logic [2:0]          tlr_cnt;
    logic [LEN_W-1:0]    bit_cnt;
    logic [LEN_W-1:0]    len_r;
    logic                is_ir_r;
    logic                err_r;
    logic [DR_WIDTH-1:0] sh_data;
    logic [DR_WIDTH-1:0] cap_data;
    logic [LEN_W-1:0]    cap_idx;
    logic                len_ok;
    logic                accept;
    logic                run;
    logic                rise_stb;
    logic                fall_stb;
`ifdef DEBUG_SCAN_RTI_WAIT_EN
    localparam int RTI_W = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;
    logic [RTI_W-1:0]    rti_cnt;
`endif

    assign len_ok    = (cmd_len != '0) && (cmd_len <= MAX_LEN);
    assign accept    = (state == ST_IDLE) && cmd_valid;
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_err   = rsp_valid && err_r;
    assign rsp_data  = rsp_valid ? cap_data : '0;

    // TCK only toggles while a TAP sequence is in progress.
    assign run = !((state == ST_IDLE) || (state == ST_RESP) ||
                   ((state == ST_TLR_INIT) && (tlr_cnt == TLR_DONE)));

    debug_scan_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (run),
        .tck      (tck),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    // SHIFT cycle 0 is the Capture->Shift entry; SHIFT cycle c>0 drives bit c-1,
    // and the EXIT1 cycle drives the last bit.
    assign cap_idx = (state == ST_EXIT1) ? (len_r - LEN_W'(1)) : (bit_cnt - LEN_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_TLR_INIT;
            tlr_cnt <= '0;
            tms     <= 1'b1;
            tdi     <= 1'b0;
            err_r   <= 1'b0;
            bit_cnt <= '0;
            len_r   <= '0;
            is_ir_r <= 1'b0;
`ifdef DEBUG_SCAN_RTI_WAIT_EN
            rti_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_TLR_INIT: begin
                    if (tlr_cnt == TLR_DONE) begin
                        state <= ST_IDLE;
                    end else if (fall_stb) begin
                        tlr_cnt <= tlr_cnt + 3'd1;
                        tms     <= (tlr_cnt < 3'(TLR_CYCLES - 1));
                    end
                end
                ST_IDLE: begin
                    if (cmd_valid) begin
                        len_r   <= cmd_len;
                        is_ir_r <= cmd_is_ir;
                        if (len_ok) begin
                            state <= ST_SEL_DR;
                            tms   <= 1'b1;
                            err_r <= 1'b0;
                        end else begin
                            state <= ST_RESP;
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_SEL_DR: begin
                    if (fall_stb) begin
                        state <= is_ir_r ? ST_SEL_IR : ST_CAPTURE;
                        tms   <= is_ir_r;
                    end
                end
                ST_SEL_IR: begin
                    if (fall_stb) begin
                        state <= ST_CAPTURE;
                        tms   <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (fall_stb) begin
                        state   <= ST_SHIFT;
                        bit_cnt <= '0;
                        tms     <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (fall_stb) begin
                        tdi <= sh_data[0];
                        // Last bit leaves Shift with tms=1.
                        if (bit_cnt == len_r - LEN_W'(1)) begin
                            state <= ST_EXIT1;
                            tms   <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + LEN_W'(1);
                        end
                    end
                end
                ST_EXIT1: begin
                    if (fall_stb) begin
                        state <= ST_UPDATE;
                        tms   <= 1'b1;
                        tdi   <= 1'b0;
                    end
                end
                ST_UPDATE: begin
                    if (fall_stb) begin
                        state <= ST_RTI;
                        tms   <= 1'b0;
`ifdef DEBUG_SCAN_RTI_WAIT_EN
                        rti_cnt <= '0;
`endif
                    end
                end
                ST_RTI: begin
                    if (fall_stb) begin
`ifdef DEBUG_SCAN_RTI_WAIT_EN
                        if (rti_cnt == RTI_W'(RTI_CYCLES - 1)) begin
                            state <= ST_RESP;
                        end else begin
                            rti_cnt <= rti_cnt + RTI_W'(1);
                        end
`else
                        state <= ST_RESP;
`endif
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state   <= ST_TLR_INIT;
                    tlr_cnt <= '0;
                    tms     <= 1'b1;
                    tdi     <= 1'b0;
                end
            endcase
        end
    end

    // Shift data and capture register: no reset needed, both are loaded on acceptance
    // and rsp_data is gated by rsp_valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            sh_data  <= cmd_data;
            cap_data <= '0;
        end else begin
            if ((state == ST_SHIFT) && fall_stb) begin
                sh_data <= sh_data >> 1;
            end
            if (rise_stb && (((state == ST_SHIFT) && (bit_cnt != '0)) || (state == ST_EXIT1))) begin
                cap_data <= cap_data | ({{(DR_WIDTH-1){1'b0}}, tdo} << cap_idx);
            end
        end
    end

endmodule

// File: tb/tb_debug_scan_master.sv
// Self-checking bench for debug_scan_master: two instances (TCK_DIV=1 and TCK_DIV=3),
// each with a TAP model whose TDO echoes TDI one TCK cycle late, and a response
// scoreboard holding expected data, error flag and latency per command.
module tb_debug_scan_master;

    localparam int DW  = 38;
    localparam int LW  = 6;
    localparam int RTI = 2;
`ifdef DEBUG_SCAN_RTI_WAIT_EN
    localparam int RTI_EXTRA = RTI - 1;
`else
    localparam int RTI_EXTRA = 0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            lat;
        int            acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: TCK_DIV=1
    logic          a_rst_n, a_cmd_valid, a_cmd_ready, a_cmd_is_ir;
    logic [LW-1:0] a_cmd_len;
    logic [DW-1:0] a_cmd_data, a_rsp_data;
    logic          a_rsp_valid, a_rsp_err, a_busy, a_tck, a_tms, a_tdi, a_tdo;
    logic          a_echo = 1'b0;
    int            a_rises = 0;
    logic [63:0]   a_tms_hist = '0;
    logic [63:0]   a_tdi_hist = '0;
    exp_t          sb_a[$];

    // Instance B: TCK_DIV=3
    logic          b_rst_n, b_cmd_valid, b_cmd_ready, b_cmd_is_ir;
    logic [LW-1:0] b_cmd_len;
    logic [DW-1:0] b_cmd_data, b_rsp_data;
    logic          b_rsp_valid, b_rsp_err, b_busy, b_tck, b_tms, b_tdi, b_tdo;
    logic          b_echo = 1'b0;
    exp_t          sb_b[$];

    debug_scan_master #(.DR_WIDTH(DW), .LEN_W(LW), .TCK_DIV(1), .RTI_CYCLES(RTI)) u_dut_a (
        .clk(clk), .reset_n(a_rst_n),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_is_ir(a_cmd_is_ir),
        .cmd_len(a_cmd_len), .cmd_data(a_cmd_data),
        .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_err(a_rsp_err),
        .busy(a_busy), .tck(a_tck), .tms(a_tms), .tdi(a_tdi), .tdo(a_tdo)
    );

    debug_scan_master #(.DR_WIDTH(DW), .LEN_W(LW), .TCK_DIV(3), .RTI_CYCLES(RTI)) u_dut_b (
        .clk(clk), .reset_n(b_rst_n),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_is_ir(b_cmd_is_ir),
        .cmd_len(b_cmd_len), .cmd_data(b_cmd_data),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
        .busy(b_busy), .tck(b_tck), .tms(b_tms), .tdi(b_tdi), .tdo(b_tdo)
    );

    // TAP models: 1-bit delay from TDI to TDO, clocked on TCK rising.
    assign a_tdo = a_echo;
    assign b_tdo = b_echo;

    always @(posedge a_tck) begin
        a_echo     <= a_tdi;
        a_rises     = a_rises + 1;
        a_tms_hist  = {a_tms_hist[62:0], a_tms};
        a_tdi_hist  = {a_tdi_hist[62:0], a_tdi};
    end

    always @(posedge b_tck) b_echo <= b_tdi;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (a_rsp_valid) begin
            if (sb_a.size() == 0) begin
                chk("a_unexpected_rsp", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_a.pop_front();
                chk("a_rsp_data", 64'(a_rsp_data), 64'(e.data));
                chk("a_rsp_err", 64'(a_rsp_err), 64'(e.err));
                chk("a_latency", 64'(cyc - e.acc + 1), 64'(e.lat));
            end
        end
        if (b_rsp_valid) begin
            if (sb_b.size() == 0) begin
                chk("b_unexpected_rsp", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_b.pop_front();
                chk("b_rsp_data", 64'(b_rsp_data), 64'(e.data));
                chk("b_rsp_err", 64'(b_rsp_err), 64'(e.err));
                chk("b_latency", 64'(cyc - e.acc + 1), 64'(e.lat));
            end
        end
    end

    function automatic logic [DW-1:0] echo_expect(input int len, input logic [DW-1:0] data);
        logic [DW-1:0] mask;
        mask = '0;
        for (int i = 0; i < DW; i++) if (i < len) mask[i] = 1'b1;
        return (data << 1) & mask;
    endfunction

    function automatic int scan_cycles(input bit is_ir, input int len);
        return len + 5 + (is_ir ? 1 : 0) + RTI_EXTRA;
    endfunction

    // Expected TMS per TCK cycle, oldest cycle in the most significant position.
    function automatic logic [63:0] tms_expect(input bit is_ir, input int len);
        logic [63:0] v;
        v = 64'd1;
        if (is_ir) v = {v[62:0], 1'b1};
        v = {v[62:0], 1'b0};
        v = {v[62:0], 1'b0};
        for (int i = 0; i < len - 1; i++) v = {v[62:0], 1'b0};
        v = {v[62:0], 1'b1};
        v = {v[62:0], 1'b1};
        for (int i = 0; i <= RTI_EXTRA; i++) v = {v[62:0], 1'b0};
        return v;
    endfunction

    function automatic logic [63:0] tdi_expect(input bit is_ir, input int len, input logic [DW-1:0] data);
        logic [63:0] v;
        v = '0;
        v = {v[62:0], 1'b0};
        if (is_ir) v = {v[62:0], 1'b0};
        v = {v[62:0], 1'b0};
        v = {v[62:0], 1'b0};
        for (int i = 0; i < len; i++) v = {v[62:0], data[i]};
        v = {v[62:0], 1'b0};
        for (int i = 0; i <= RTI_EXTRA; i++) v = {v[62:0], 1'b0};
        return v;
    endfunction

    function automatic logic [63:0] low_mask(input int n);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) if (i < n) m[i] = 1'b1;
        return m;
    endfunction

    task automatic send(input bit sel, input bit is_ir, input int len,
                        input logic [DW-1:0] data, input bit push);
        bit   ok;
        exp_t e;
        int   div;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if ((sel ? b_cmd_ready : a_cmd_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("cmd_ready_timeout", 64'd0, 64'd1);
            return;
        end
        if (sel) begin
            b_cmd_valid = 1'b1; b_cmd_is_ir = is_ir; b_cmd_len = LW'(len); b_cmd_data = data;
        end else begin
            a_cmd_valid = 1'b1; a_cmd_is_ir = is_ir; a_cmd_len = LW'(len); a_cmd_data = data;
        end
        @(posedge clk);
        #1;
        a_cmd_valid = 1'b0;
        b_cmd_valid = 1'b0;
        if (push) begin
            div   = sel ? 3 : 1;
            e.acc = cyc;
            if (len == 0 || len > DW) begin
                e.data = '0;
                e.err  = 1'b1;
                e.lat  = 1;
            end else begin
                e.data = echo_expect(len, data);
                e.err  = 1'b0;
                e.lat  = scan_cycles(is_ir, len) * 2 * div + 1;
            end
            if (sel) sb_b.push_back(e);
            else     sb_a.push_back(e);
        end
    endtask

    task automatic wait_drain(input bit sel);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ((sel ? sb_b.size() : sb_a.size()) == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(sel ? "b_rsp_timeout" : "a_rsp_timeout", 64'd0, 64'd1);
    endtask

    // Instance A after reset release: 6 TCK pulses, TMS 1,1,1,1,1,0, ready 1 clk after.
    task automatic check_tlr_a(input string tag);
        int   r0, k;
        bit   fell;
        logic prev;
        r0   = a_rises;
        k    = -1;
        fell = 1'b0;
        prev = a_tck;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fell) begin
                k++;
                if (a_cmd_ready) break;
            end else if (prev && !a_tck && (a_rises - r0) == 6) begin
                fell = 1'b1;
                k    = 0;
                chk({tag, "_ready_early"}, 64'(a_cmd_ready), 64'd0);
            end
            prev = a_tck;
        end
        chk({tag, "_pulses"}, 64'(a_rises - r0), 64'd6);
        chk({tag, "_tms"}, a_tms_hist & 64'h3f, 64'b111110);
        chk({tag, "_ready_delay"}, 64'(k), 64'd1);
    endtask

    task automatic scan_a(input string tag, input bit is_ir, input int len, input logic [DW-1:0] data);
        int n, r0;
        n  = scan_cycles(is_ir, len);
        r0 = a_rises;
        send(1'b0, is_ir, len, data, 1'b1);
        wait_drain(1'b0);
        chk({tag, "_tck_cycles"}, 64'(a_rises - r0), 64'(n));
        chk({tag, "_tms"}, a_tms_hist & low_mask(n), tms_expect(is_ir, len));
        chk({tag, "_tdi"}, a_tdi_hist & low_mask(n), tdi_expect(is_ir, len, data));
        chk({tag, "_idle_tms"}, 64'(a_tms), 64'd0);
    endtask

    initial begin
        int r0;
        bit ok;
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_cmd_valid = 1'b0; a_cmd_is_ir = 1'b0; a_cmd_len = '0; a_cmd_data = '0;
        b_cmd_valid = 1'b0; b_cmd_is_ir = 1'b0; b_cmd_len = '0; b_cmd_data = '0;
        repeat (3) @(negedge clk);

        chk("rst_tck", 64'(a_tck), 64'd0);
        chk("rst_tms", 64'(a_tms), 64'd1);
        chk("rst_tdi", 64'(a_tdi), 64'd0);
        chk("rst_cmd_ready", 64'(a_cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(a_rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(a_rsp_data), 64'd0);
        chk("rst_rsp_err", 64'(a_rsp_err), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd1);

        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        check_tlr_a("tlr");
        chk("idle_busy", 64'(a_busy), 64'd0);

        scan_a("dr8", 1'b0, 8, 38'hA5);
        scan_a("ir2", 1'b1, 2, 38'h2);
        scan_a("dr1", 1'b0, 1, 38'h1);
        scan_a("dr38", 1'b0, 38, 38'h2_AAAA_5555);
        scan_a("dr_rand", 1'b0, 13, DW'({$urandom(), $urandom()}));

        // Illegal lengths: error response after one clk, no TCK activity.
        r0 = a_rises;
        send(1'b0, 1'b0, 0, 38'h3F, 1'b1);
        wait_drain(1'b0);
        send(1'b0, 1'b1, 39, 38'h3F, 1'b1);
        wait_drain(1'b0);
        chk("illegal_no_tck", 64'(a_rises - r0), 64'd0);

        // Full-width scan on the TCK_DIV=3 instance.
        send(1'b1, 1'b0, 38, 38'h2_AAAA_5555, 1'b1);
        wait_drain(1'b1);

        // Reset during bit 10 of a 38-bit DR scan (bit 10 is TCK cycle 14).
        r0 = a_rises;
        send(1'b0, 1'b0, 38, 38'h15_5555_AAAA, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((a_rises - r0) == 14) begin
                ok = 1'b1;
                break;
            end
        end
        chk("midrst_reached_bit10", 64'(ok), 64'd1);
        #1;
        a_rst_n = 1'b0;
        #1;
        chk("midrst_tck", 64'(a_tck), 64'd0);
        chk("midrst_tms", 64'(a_tms), 64'd1);
        chk("midrst_busy", 64'(a_busy), 64'd1);
        repeat (3) @(negedge clk);
        a_rst_n = 1'b1;
        check_tlr_a("tlr2");
        scan_a("after_rst", 1'b0, 8, 38'h3C);

        repeat (5) @(negedge clk);
        chk("sb_a_empty", 64'(sb_a.size()), 64'd0);
        chk("sb_b_empty", 64'(sb_b.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
